// File: rtl/mem_access_ctrl_if.sv
// Handshaked data-memory bus between mem_access_ctrl (master) and the data memory (slave).
interface mem_access_ctrl_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Memory-stage sequencer: one req/ack transaction per EX/MEM load or store, stalling via freeze.
// Define MEM_POSTED_WRITE_EN to post stores into a one-entry write buffer (adds the DRAIN state).
module mem_access_ctrl #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read_en,
    input  logic              mem_write_en,
    input  logic [31:0]       alu_res,
    input  logic [DATA_W-1:0] val_rm,
    output logic              freeze,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    mem_access_ctrl_if.master mem
);

`ifdef MEM_POSTED_WRITE_EN
    typedef enum logic [1:0] {StIdle, StReq, StDone, StDrain} state_e;
`else
    typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;
`endif

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    logic op_present;
    logic freeze_c;
    logic req_c;
    logic rd_valid_c;

    assign op_present = mem_read_en | mem_write_en;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        rd_data_d  = rd_data_q;
        freeze_c   = 1'b0;
        req_c      = 1'b0;
        rd_valid_c = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (op_present) begin
                    addr_d  = alu_res[ADDR_W-1:0];
                    wdata_d = val_rm;
                    we_d    = mem_write_en;
`ifdef MEM_POSTED_WRITE_EN
                    // Request registers double as the write buffer; a store retires at once.
                    if (mem_write_en) begin
                        state_d = StDrain;
                    end else begin
                        freeze_c = 1'b1;
                        state_d  = StReq;
                    end
`else
                    freeze_c = 1'b1;
                    state_d  = StReq;
`endif
                end
            end

            StReq: begin
                req_c    = 1'b1;
                freeze_c = 1'b1;
                if (mem.mem_ack) begin
                    if (!we_q) begin
                        rd_data_d = mem.mem_rdata;
                    end
                    state_d = StDone;
                end
            end

            // Op inputs here still belong to the instruction that just completed.
            StDone: begin
                rd_valid_c = ~we_q;
                state_d    = StIdle;
            end

`ifdef MEM_POSTED_WRITE_EN
            // A new op waits in EX/MEM until the buffered store is acknowledged.
            StDrain: begin
                req_c    = 1'b1;
                freeze_c = op_present;
                if (mem.mem_ack) begin
                    state_d = StIdle;
                end
            end
`endif

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Freeze is combinational from the op inputs in IDLE, so gate it while reset is held.
    assign freeze        = rst_n & freeze_c;
    assign rd_valid      = rd_valid_c;
    assign rd_data       = rd_data_q;
    assign mem.mem_req   = req_c;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;

    a_op_exclusive: assert property (
        @(posedge clk) disable iff (!rst_n) !(mem_read_en && mem_write_en)
    );

    a_req_stable: assert property (
        @(posedge clk) disable iff (!rst_n)
        (mem.mem_req && !mem.mem_ack) |=>
            (mem.mem_req && $stable(mem.mem_addr) && $stable(mem.mem_we) && $stable(mem.mem_wdata))
    );

    a_valid_unfrozen: assert property (
        @(posedge clk) disable iff (!rst_n) rd_valid |-> !freeze
    );

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Memory-stage sequencer between the EX/MEM pipeline register and a handshaked data memory. Detects a load or store in the EX/MEM stage and issues one req/ack transaction to memory. Holds the pipeline via `freeze` until the access completes, then presents load data for write-back. Optionally posts stores into a one-entry buffer so they do not stall the pipeline.

## Interface
- `ADDR_W`, 32: memory address width; taken from the low bits of `alu_res`.
- `DATA_W`, 32: data width of store data, load data and the memory bus.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mem_read_en`  in  1  load present in EX/MEM stage.
- `mem_write_en`  in  1  store present in EX/MEM stage; never high together with `mem_read_en`.
- `alu_res`  in  32  effective address.
- `val_rm`  in  DATA_W  store data.
- `freeze`  out  1  hold for IF/ID/EX/EX-MEM pipeline registers.
- `rd_data`  out  DATA_W  load result.
- `rd_valid`  out  1  `rd_data` valid this cycle (one-cycle pulse).
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  1 = write, 0 = read.
- `mem_addr`  out  ADDR_W  request address.
- `mem_wdata`  out  DATA_W  write data.
- `mem_rdata`  in  DATA_W  read data; valid with `mem_ack`.
- `mem_ack`  in  1  one-cycle completion from memory.

## Operation
- FSM states: IDLE, REQ, DONE. With `MEM_POSTED_WRITE_EN` the FSM adds DRAIN.
- IDLE, no op: `freeze`=0.
- IDLE, op present: `freeze`=1 combinationally. Latch address (`alu_res[ADDR_W-1:0]`), data and direction into the request registers. Go to REQ.
- REQ: `mem_req`=1 and `freeze`=1. `mem_addr`, `mem_we` and `mem_wdata` stay stable until `mem_ack`.
  - On `mem_ack`, capture `mem_rdata` into `rd_data` (load only). Go to DONE.
- DONE: `freeze`=0 so the stalled instruction advances. `rd_valid`=1 for a load, 0 for a store. `mem_req`=0. Go to IDLE unconditionally.
  - The op signals seen in DONE belong to the instruction that just completed and are ignored.
- `rd_data` holds its value until the next load completes.
- `mem_ack` outside REQ is ignored.
- Only the low `ADDR_W` bits of `alu_res` are used. No alignment check.

## Timing
- Reset (`rst_n`=0, any state, including mid-REQ): state IDLE; `freeze`, `mem_req`, `mem_we`, `rd_valid` = 0; `mem_addr`, `mem_wdata`, `rd_data` = 0.
  - `freeze` is forced 0 during reset regardless of the op inputs.
  - An in-flight ack is dropped; memory must tolerate the abandoned request.
- Request is registered: `mem_req` rises on the edge after the op is detected in IDLE.
- Minimum access: ack in the first REQ cycle gives 2 frozen cycles (IDLE, REQ) plus 1 DONE cycle.
- Each extra ack wait cycle adds 1 frozen cycle.
- `rd_valid` is high in the DONE cycle. The load result is written into MEM/WB at the end of that cycle.
- Back-to-back memory ops: each op passes through IDLE → REQ → DONE. No overlap.

## Configuration
- `MEM_POSTED_WRITE_EN` undefined: stores stall exactly like loads, as described above.
- `MEM_POSTED_WRITE_EN` defined: adds a one-entry write buffer and the DRAIN state.
  - Store in IDLE with buffer empty: latch into the buffer, `freeze`=0, go to DRAIN. The instruction advances with zero stall.
  - DRAIN: `mem_req`=1, `mem_we`=1.
    - On `mem_ack` with no new op: buffer empties, go to IDLE.
    - On `mem_ack` with a new op present: the op is evaluated as in IDLE in the next cycle.
  - Any load or store arriving during DRAIN: `freeze`=1 until the drain ack. It then proceeds normally from IDLE, so a load after a store to the same address sees the stored data.
  - Reset empties the buffer.

## Test plan
- Reset mid-REQ: assert load, stall memory ack, pull `rst_n` low → `mem_req`, `freeze`, `rd_valid` drop to 0 immediately; after release, IDLE with no request.
- Load addr 0x40, ack in first REQ cycle, `mem_rdata`=0xDEADBEEF → `freeze` high exactly 2 cycles; `rd_valid`=1 with `rd_data`=0xDEADBEEF in DONE.
- Store addr 0x80 data 0x12345678, ack after 3 wait cycles → `mem_we`=1; addr/wdata stable for all 4 REQ cycles; `freeze` high 5 cycles; `rd_valid` stays 0.
- Spurious `mem_ack` while IDLE with no op → no state change, `freeze`=0, `rd_valid`=0.
- Two consecutive loads (0x10 then 0x14), immediate acks → two `rd_valid` pulses 3 cycles apart with the correct data each.
- `MEM_POSTED_WRITE_EN`: store to 0x20 (0xA5A5A5A5) followed next cycle by load from 0x20, ack after 2 cycles → store `freeze`=0; load frozen until drain ack; load request issued after the write; `rd_data`=0xA5A5A5A5.
